// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mm:ss stopwatch.
// Holds the FSM state encoding, BCD digit limits and the one-second BCD increment.
// Purely combinational content; no state lives here.
package stopwatch_pkg;

    // Width of one BCD digit
    localparam int DIG_W = 4;

    // Highest legal value of a units digit and of a tens digit
    localparam logic [DIG_W-1:0] LIM_UNITS = 4'd9;
    localparam logic [DIG_W-1:0] LIM_TENS  = 4'd5;

    // Prescaler width; TICK_DIV must fit in it
    localparam int PRESC_W = 8;

    // Run-control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    // Displayed time, most significant digit first
    typedef struct packed {
        logic [DIG_W-1:0] min_t;
        logic [DIG_W-1:0] min_u;
        logic [DIG_W-1:0] sec_t;
        logic [DIG_W-1:0] sec_u;
    } sw_time_t;

    // Result of stepping one digit: new value plus carry into the next digit
    typedef struct packed {
        logic             carry;
        logic [DIG_W-1:0] dig;
    } bcd_step_t;

    // Result of a one-second increment: new time plus wrap out of 59:59
    typedef struct packed {
        logic     wrap;
        sw_time_t t;
    } sw_inc_t;

    // Step one digit when enabled. A digit at or above its limit rolls to 0
    // and carries, so a corrupted digit can never be pushed further out of range.
    function automatic bcd_step_t bcd_step(input logic [DIG_W-1:0] dig,
                                           input logic [DIG_W-1:0] lim,
                                           input logic             en);
        bcd_step_t r;
        r.carry = 1'b0;
        r.dig   = dig;
        if (en) begin
            if (dig >= lim) begin
                r.dig   = '0;
                r.carry = 1'b1;
            end else begin
                r.dig = dig + 4'd1;
            end
        end
        return r;
    endfunction

    // Add one second with the carry rippling through all four digits.
    function automatic sw_inc_t time_inc(input sw_time_t t);
        sw_inc_t   r;
        bcd_step_t su;
        bcd_step_t st;
        bcd_step_t mu;
        bcd_step_t mt;
        su = bcd_step(t.sec_u, LIM_UNITS, 1'b1);
        st = bcd_step(t.sec_t, LIM_TENS,  su.carry);
        mu = bcd_step(t.min_u, LIM_UNITS, st.carry);
        mt = bcd_step(t.min_t, LIM_TENS,  mu.carry);
        r.t.sec_u = su.dig;
        r.t.sec_t = st.dig;
        r.t.min_u = mu.dig;
        r.t.min_t = mt.dig;
        r.wrap    = mt.carry;
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes one asynchronous level into CLK and emits a 1-cycle pulse per rising edge.
// Latency: pulse register rises on the (SYNC_STAGES+1)-th edge counting the first edge that samples the input high.
// No backpressure: a pulse is produced unconditionally; a level held across reset is ignored until it falls.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_i,
    output logic pulse_o
);

    // Synchronizer chain and a parallel chain marking which stages hold real samples
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] vld_q;
    logic [SYNC_STAGES-1:0] vld_d;

    // Previous synchronized level, arm flag and the registered pulse
    logic dly_q;
    logic dly_d;
    logic armed_q;
    logic armed_d;
    logic pulse_q;
    logic pulse_d;

    logic lvl;
    logic lvl_vld;

    assign lvl     = sync_q[SYNC_STAGES-1];
    assign lvl_vld = vld_q[SYNC_STAGES-1];

    // Shift the input and the sample-valid marker down the chain; detect a rise once armed.
    // Arming requires a genuine low sample after reset, so an input that was already high
    // when reset released cannot masquerade as a new press.
    always_comb begin
        sync_d    = sync_q;
        vld_d     = vld_q;
        sync_d[0] = async_i;
        vld_d[0]  = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
        dly_d   = lvl;
        armed_d = armed_q | (lvl_vld & ~lvl);
        pulse_d = armed_q & lvl_vld & lvl & ~dly_q;
    end

    // State registers; reset discards any sample or pulse in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '0;
            vld_q   <= '0;
            dly_q   <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            dly_q   <= dly_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss BCD stopwatch with run/pause/clear control and a sticky wrap flag.
// Latency: digits/RUNNING update on the edge that consumes an input pulse (SYNC_STAGES+1 edges after sampling).
// No backpressure: every qualified pulse is consumed in the cycle it appears.
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       START_STOP,
    input  logic       CLEAR,
    output logic [3:0] SEC_U,
    output logic [3:0] SEC_T,
    output logic [3:0] MIN_U,
    output logic [3:0] MIN_T,
    output logic       RUNNING,
    output logic       OVF
);

    import stopwatch_pkg::*;

    // Prescaler value at which the next counted tick rolls over into a second
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    // Pulses from the three synchronized inputs
    logic tick_pls;
    logic start_pls;
    logic clr_pls;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .CLK     (CLK),
        .RST     (RST),
        .async_i (TICK),
        .pulse_o (tick_pls)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .CLK     (CLK),
        .RST     (RST),
        .async_i (START_STOP),
        .pulse_o (start_pls)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
        .CLK     (CLK),
        .RST     (RST),
        .async_i (CLEAR),
        .pulse_o (clr_pls)
    );

    sw_state_t          state_q;
    sw_state_t          state_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    sw_time_t           time_q;
    sw_time_t           time_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               running_q;
    logic               running_d;

    sw_inc_t            inc;
    logic               count_tick;

    // Next state, prescaler and time. Clear wins over everything. A tick is judged
    // against the current state, so a tick with a start in RUN still counts while a
    // tick with a start in PAUSE does not.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        ovf_d      = ovf_q;
        inc        = '0;
        count_tick = tick_pls & (state_q == ST_RUN);

        if (clr_pls) begin
            state_d = ST_IDLE;
            presc_d = '0;
            time_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (start_pls) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end

            if (count_tick) begin
                if (presc_q >= PRESC_LAST) begin
                    presc_d = '0;
                    inc     = time_inc(time_q);
                    time_d  = inc.t;
                    if (inc.wrap) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    // Registers for state, prescaler, digits and flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    assign SEC_U   = time_q.sec_u;
    assign SEC_T   = time_q.sec_t;
    assign MIN_U   = time_q.min_u;
    assign MIN_T   = time_q.min_t;
    assign RUNNING = running_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a behavioural model feeds an expected-output queue.
// Two instances share stimulus: default TICK_DIV=1 (modelled) and TICK_DIV=4 (constant checks).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stopwatch_counter;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        logic       run;
        logic       ovf;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick;
    logic ss;
    logic clr;

    logic [3:0] a_su, a_st, a_mu, a_mt;
    logic       a_run, a_ovf;
    logic [3:0] b_su, b_st, b_mu, b_mt;
    logic       b_run, b_ovf;

    stopwatch_counter dut (
        .CLK        (clk),
        .RST        (rst),
        .TICK       (tick),
        .START_STOP (ss),
        .CLEAR      (clr),
        .SEC_U      (a_su),
        .SEC_T      (a_st),
        .MIN_U      (a_mu),
        .MIN_T      (a_mt),
        .RUNNING    (a_run),
        .OVF        (a_ovf)
    );

    stopwatch_counter #(.SYNC_STAGES(2), .TICK_DIV(4)) dut4 (
        .CLK        (clk),
        .RST        (rst),
        .TICK       (tick),
        .START_STOP (ss),
        .CLEAR      (clr),
        .SEC_U      (b_su),
        .SEC_T      (b_st),
        .MIN_U      (b_mu),
        .MIN_T      (b_mt),
        .RUNNING    (b_run),
        .OVF        (b_ovf)
    );

    obs_t got_a;
    obs_t got_b;
    assign got_a = {a_mt, a_mu, a_st, a_su, a_run, a_ovf};
    assign got_b = {b_mt, b_mu, b_st, b_su, b_run, b_ovf};

    int checks   = 0;
    int failures = 0;

    obs_t exp_q[$];

    // Behavioural model of the TICK_DIV=1 instance (state 0 idle, 1 run, 2 pause)
    int m_state;
    int m_sec;
    int m_ovf;
    int m_presc;
    localparam int M_DIV = 1;

    function automatic obs_t mk(int mt, int mu, int st, int su, int run, int ovf);
        obs_t o;
        o.mt  = 4'(mt);
        o.mu  = 4'(mu);
        o.st  = 4'(st);
        o.su  = 4'(su);
        o.run = 1'(run);
        o.ovf = 1'(ovf);
        return o;
    endfunction

    function automatic obs_t model_obs();
        return mk(m_sec / 600, (m_sec / 60) % 10, (m_sec / 10) % 6, m_sec % 10,
                  (m_state == 1) ? 1 : 0, m_ovf);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_sec   = 0;
        m_ovf   = 0;
        m_presc = 0;
    endtask

    task automatic model_step(input logic t, input logic s, input logic c);
        if (c) begin
            model_reset();
        end else begin
            if (t && m_state == 1) begin
                m_presc++;
                if (m_presc == M_DIV) begin
                    m_presc = 0;
                    m_sec++;
                    if (m_sec == 3600) begin
                        m_sec = 0;
                        m_ovf = 1;
                    end
                end
            end
            if (s) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic chk(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare the main instance against the oldest queued expectation
    task automatic chk_pop(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, got_a);
        end else begin
            e = exp_q.pop_front();
            chk(tag, got_a, e);
        end
    endtask

    // One button/tick event: 2 cycles high, 2 low; outputs settle on the 4th edge
    task automatic op(input logic t, input logic s, input logic c, input string tag);
        model_step(t, s, c);
        exp_q.push_back(model_obs());
        tick = t;
        ss   = s;
        clr  = c;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        ss   = 1'b0;
        clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk_pop(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_obs());
        repeat (2) @(negedge clk);
        chk_pop("reset_a");
        chk("reset_b", got_b, mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        ss   = 1'b0;
        clr  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Start, then first tick with exact latency, then 9 more
        op(1'b0, 1'b1, 1'b0, "start_run");
        model_step(1'b1, 1'b0, 1'b0);
        exp_q.push_back(model_obs());
        tick = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("tick_lat_early", got_a, mk(0, 0, 0, 0, 1, 0));
        @(negedge clk);
        chk_pop("tick_lat_edge");
        for (int i = 0; i < 9; i++) op(1'b1, 1'b0, 1'b0, "tick_to_10");
        chk("ten_sec", got_a, mk(0, 0, 1, 0, 1, 0));

        // Pause holds, resume continues; tick+start coincidences
        do_reset();
        op(1'b0, 1'b1, 1'b0, "start2");
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 1'b0, "tick_to_7");
        op(1'b0, 1'b1, 1'b0, "pause");
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, "pause_hold");
        chk("pause_at_7", got_a, mk(0, 0, 0, 7, 0, 0));
        op(1'b0, 1'b1, 1'b0, "resume");
        op(1'b1, 1'b0, 1'b0, "resume_tick");
        chk("resume_at_8", got_a, mk(0, 0, 0, 8, 1, 0));
        op(1'b1, 1'b1, 1'b0, "tick_start_in_run");
        op(1'b1, 1'b1, 1'b0, "tick_start_in_pause");
        chk("coincide_result", got_a, mk(0, 0, 0, 9, 1, 0));

        // Wrap at 59:59, sticky OVF, then clear+tick at 12:34
        do_reset();
        op(1'b0, 1'b1, 1'b0, "start3");
        for (int i = 0; i < 3598; i++) op(1'b1, 1'b0, 1'b0, "preload");
        chk("at_5958", got_a, mk(5, 9, 5, 8, 1, 0));
        op(1'b1, 1'b0, 1'b0, "to_5959");
        op(1'b1, 1'b0, 1'b0, "wrap");
        chk("wrap_ovf", got_a, mk(0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, "ovf_sticky");
        for (int i = 0; i < 749; i++) op(1'b1, 1'b0, 1'b0, "to_1234");
        chk("at_1234", got_a, mk(1, 2, 3, 4, 1, 1));
        op(1'b1, 1'b0, 1'b1, "clear_with_tick");
        chk("cleared", got_a, mk(0, 0, 0, 0, 0, 0));
        op(1'b1, 1'b0, 1'b0, "tick_in_idle");
        op(1'b0, 1'b1, 1'b1, "clear_with_start");

        // TICK_DIV=4 instance: 7 ticks -> 00:01, 8th proves prescaler was 3
        do_reset();
        op(1'b0, 1'b1, 1'b0, "start4");
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 1'b0, "div4_ticks");
        chk("div4_7ticks", got_b, mk(0, 0, 0, 1, 1, 0));
        op(1'b1, 1'b0, 1'b0, "div4_8th");
        chk("div4_8ticks", got_b, mk(0, 0, 0, 2, 1, 0));
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_obs());
        @(negedge clk);
        rst = 1'b0;
        chk_pop("rst_1cyc_a");
        chk("rst_1cyc_b", got_b, mk(0, 0, 0, 0, 0, 0));
        repeat (4) @(negedge clk);

        // START_STOP held high across reset release: no start until a new rise
        ss  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_start_ignored", got_a, mk(0, 0, 0, 0, 0, 0));
        ss = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_released", got_a, mk(0, 0, 0, 0, 0, 0));
        op(1'b0, 1'b1, 1'b0, "new_start_rise");
        chk("held_then_run", got_a, mk(0, 0, 0, 0, 1, 0));
        chk("held_then_run_b", got_b, mk(0, 0, 0, 0, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
